// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: controller states, SPI mode encoding and default frame width.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } spi_state_e;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0      = 2'b00;
    localparam int         DEFAULT_DATA_W = 16;

endpackage

// File: rtl/spi_slave_responder_if.sv
// SPI pins plus the parallel TX/RX handshake of the slave responder.
interface spi_slave_responder_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic              sclk;
    logic              ss;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              tx_underrun;
    logic              busy;

    modport slave (
        input  sclk, ss, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, frame_err, tx_underrun, busy
    );

    modport master (
        output sclk, ss, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, frame_err, tx_underrun, busy
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus an edge-detect flop
// giving single-cycle rise/fall pulses aligned with the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              edge_q, edge_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        edge_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            edge_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise =  q & ~edge_q;
    assign fall = ~q &  edge_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversamples sclk/ss/mosi in the clk domain, shifts one
// DATA_W-bit word each way per frame, with a one-word TX holding register.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_slave_responder_if.slave  bus
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    // Idle levels for {ss, sclk, mosi}; sclk idles at CPOL.
    localparam logic [2:0]       SYNC_RST = {1'b1, SPI_MODE0[1], 1'b0};

    logic [2:0] pin_raw, pin_lvl, pin_rise, pin_fall;
    logic       ss_lvl, ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_lvl;
    logic       unused_sync;

    assign pin_raw = {bus.ss, bus.sclk, bus.mosi};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            spi_sync_edge #(
                .STAGES    (SYNC_STAGES),
                .RESET_VAL (SYNC_RST[gi])
            ) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (pin_raw[gi]),
                .q     (pin_lvl[gi]),
                .rise  (pin_rise[gi]),
                .fall  (pin_fall[gi])
            );
        end
    endgenerate

    assign ss_lvl      = pin_lvl[2];
    assign ss_rise     = pin_rise[2];
    assign ss_fall     = pin_fall[2];
    assign sclk_rise   = pin_rise[1];
    assign sclk_fall   = pin_fall[1];
    assign mosi_lvl    = pin_lvl[0];
    assign unused_sync = &{1'b0, pin_lvl[1], pin_rise[0], pin_fall[0]};

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_pend_q, rx_pend_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              underrun_q, underrun_d;
    logic              err_seen_q, err_seen_d;
    logic              tx_accept;

    assign tx_accept = bus.tx_valid & ~hold_full_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_pend_d   = 1'b0;
        rx_valid_d  = rx_pend_q;
        frame_err_d = 1'b0;
        underrun_d  = 1'b0;
        err_seen_d  = err_seen_q;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d     = SHIFT;
                    bit_cnt_d   = '0;
                    err_seen_d  = 1'b0;
                    tx_sh_d     = hold_full_q ? hold_q : '0;
                    underrun_d  = ~hold_full_q;
                    hold_full_d = 1'b0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    frame_err_d = 1'b1;
                    tx_sh_d     = '0;
                end else begin
                    if (sclk_rise) begin
                        rx_sh_d   = {rx_sh_q[DATA_W-2:0], mosi_lvl};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d = rx_sh_d;
                            rx_pend_d = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                    if (sclk_fall) begin
                        tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            HOLD: begin
                // Surplus sclk edges after a full word are flagged once per frame.
                if (sclk_rise && !err_seen_q) begin
                    frame_err_d = 1'b1;
                    err_seen_d  = 1'b1;
                end
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A word accepted in the frame-start cycle lands in the just-freed holding register.
        if (tx_accept) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_pend_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            underrun_q  <= 1'b0;
            err_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_pend_q   <= rx_pend_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            underrun_q  <= underrun_d;
            err_seen_q  <= err_seen_d;
        end
    end

    assign bus.miso_oe     = ~ss_lvl;
    assign bus.miso        = ~ss_lvl & (state_q != IDLE) & tx_sh_q[DATA_W-1];
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/spi_slave_responder.md
SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 Parameter DATA_W, default 16, sets the frame length in bits; legal range 8..32.
REQ-002 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on sclk, ss and mosi; legal range 2..3.
REQ-003 clk  input  1  system clock; all logic is in this single domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 sclk  input  1  SPI clock from the external master; SPI mode 0 (CPOL=0, CPHA=0).
REQ-006 ss  input  1  active-low slave select from the master.
REQ-007 mosi  input  1  serial data from the master, MSB first.
REQ-008 miso  output  1  serial data to the master, MSB first.
REQ-009 miso_oe  output  1  high while the slave is selected; the pad tristates miso when this is low.
REQ-010 tx_data  input  DATA_W  next word to transmit.
REQ-011 tx_valid  input  1  tx_data is valid.
REQ-012 tx_ready  output  1  the TX holding register is empty.
REQ-013 rx_data  output  DATA_W  last complete received word.
REQ-014 rx_valid  output  1  one-clk pulse: rx_data updated.
REQ-015 frame_err  output  1  one-clk pulse: ss deasserted mid-frame, or extra sclk edges after a full word.
REQ-016 tx_underrun  output  1  one-clk pulse: a frame started with the holding register empty.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 sclk, ss and mosi each pass through SYNC_STAGES flops followed by one edge-detect flop; all three share the same delay, so mosi stays aligned to sclk.
REQ-019 Supported sclk frequency is at most clk/8.
REQ-020 TX handshake: when tx_valid and tx_ready are both high in a cycle, tx_data is captured into the holding register; tx_ready drops to 0 on the next cycle.
REQ-021 The state machine has three states: IDLE, SHIFT and HOLD.
REQ-022 IDLE -> SHIFT on a detected ss falling edge; the cycle of the transition:
- the holding register moves into the TX shift register;
- the holding register is freed, so tx_ready returns to 1 on the next cycle.
REQ-023 If the holding register is empty at frame start, the shift register loads all zeros and tx_underrun pulses.
REQ-024 If tx_valid and frame start coincide with the holding register empty, the new word goes to the holding register (not the shift register), and tx_underrun still pulses.
REQ-025 In SHIFT, miso presents the shift-register MSB from the cycle after the ss fall is detected.
REQ-026 In SHIFT, each detected sclk rising edge shifts the synchronized mosi into the RX shift register LSB and increments the bit counter.
REQ-027 In SHIFT, each detected sclk falling edge shifts the TX register left by one, zero-filled.
REQ-028 On the DATA_W-th rising edge: rx_data loads the assembled word, rx_valid pulses 1 clk later, and the state goes to HOLD.
REQ-029 HOLD -> IDLE on ss rising.
REQ-030 An sclk rising edge detected in HOLD pulses frame_err once per frame and is otherwise ignored.
REQ-031 ss rising in SHIFT with the bit count below DATA_W:
- state goes to IDLE;
- frame_err pulses;
- rx_data and rx_valid are untouched;
- the partially sent TX word is discarded.
REQ-032 Back-to-back frames (ss high for at most 2 clk after synchronization) are supported with no lost word.
REQ-033 miso_oe equals the synchronized, inverted ss; miso is 0 whenever miso_oe is 0.

Reset
REQ-034 While rst_n is low, all of the following are held:
- state=IDLE, bit counter=0;
- holding register empty, so tx_ready=1;
- shift registers=0, rx_data=0;
- miso=0, miso_oe=0;
- rx_valid, frame_err, tx_underrun and busy=0;
- synchronizer flops preset to idle levels (ss=1, sclk=0, mosi=0).
REQ-035 Reset asserted mid-frame aborts the frame with no pulse output.
REQ-036 After reset releases, a frame is only recognized from a fresh ss falling edge.

Structure
REQ-037 A shared package spi_pkg holds:
- the state enumeration (IDLE, SHIFT, HOLD);
- the SPI_MODE0 constant;
- the default DATA_W.
REQ-038 One sub-module, spi_sync_edge, is instantiated once per input; it provides a synchronizer plus rise/fall pulses.

Verification
REQ-039 Single frame: tx word 0xA5C3 preloaded, master sends 0x1234 at clk/8 -> master receives 0xA5C3; rx_data=0x1234; exactly one rx_valid pulse.
REQ-040 Underrun: no tx word loaded, master sends 0xFFFF -> master receives 0x0000; one tx_underrun pulse; rx_data=0xFFFF.
REQ-041 Abort: ss rises after 9 bits of 0xBEEF -> frame_err pulses once; no rx_valid; rx_data keeps its prior value; next full frame is received correctly.
REQ-042 Over-clock: 17 sclk pulses in one frame of 0x0F0F -> rx_valid once with 0x0F0F; frame_err once.
REQ-043 Back-to-back: two frames with ss high for 1 sclk period, tx words 0x1111 then 0x2222 -> master receives both in order; tx_ready toggles once per frame.
REQ-044 Reset: rst_n pulsed low mid-frame -> all outputs at reset values within the same clk; no pulses; next frame clean.
